// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - commit-stage trap sequencer: interrupt/exception/ertn strobes, timed flush, redirect handshake
// Optional TRAP_TLBR_EN: exceptions with ecode 0x3F redirect to i_tlbrentry instead of i_eentry.
module trap_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_commit_valid,
  output logic        o_commit_ready,
  input  logic [31:0] i_commit_pc,
  input  logic [5:0]  i_commit_ecode,
  input  logic [8:0]  i_commit_esubcode,
  input  logic        i_commit_is_ertn,
  input  logic        i_is_interrupt,
  input  logic [31:0] i_eentry,
  input  logic [31:0] i_tlbrentry,
  input  logic [31:0] i_era,
  output logic        o_trap_valid,
  output logic [5:0]  o_trap_ecode,
  output logic [8:0]  o_trap_esubcode,
  output logic [31:0] o_trap_epc,
  output logic        o_ertn_valid,
  output logic        o_flush,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  input  logic        i_redirect_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_commit_ready;
  logic        r_trap_valid;
  logic        r_ertn_valid;
  logic        r_flush;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic [5:0]  r_trap_ecode;
  logic [8:0]  r_trap_esubcode;
  logic [31:0] r_trap_epc;

  logic        w_accept;
  logic        w_is_exc;
  logic        w_take_int;
  logic        w_take_exc;
  logic        w_take_ertn;
  logic [31:0] w_exc_target;

  assign w_accept    = i_commit_valid & (r_state == S_IDLE);
  assign w_is_exc    = (i_commit_ecode != 6'd0);
  // Strict priority: interrupt over exception over ertn; losers are simply dropped.
  assign w_take_int  = w_accept & i_is_interrupt;
  assign w_take_exc  = w_accept & ~i_is_interrupt & w_is_exc;
  assign w_take_ertn = w_accept & ~i_is_interrupt & ~w_is_exc & i_commit_is_ertn;

`ifdef TRAP_TLBR_EN
  assign w_exc_target = (i_commit_ecode == ECODE_TLBR) ? i_tlbrentry : i_eentry;
`else
  logic w_unused_tlbr;
  assign w_unused_tlbr = (^i_tlbrentry) ^ (&ECODE_TLBR);
  assign w_exc_target  = i_eentry;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_cnt            <= 4'd0;
      r_commit_ready   <= 1'b1;
      r_trap_valid     <= 1'b0;
      r_ertn_valid     <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_trap_ecode     <= 6'd0;
      r_trap_esubcode  <= 9'd0;
      r_trap_epc       <= 32'd0;
    end else begin
      r_trap_valid <= 1'b0;
      r_ertn_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take_int || w_take_exc || w_take_ertn) begin
            r_state        <= S_FLUSH;
            r_cnt          <= CNT_LOAD;
            r_commit_ready <= 1'b0;
            r_flush        <= 1'b1;
          end
          if (w_take_int) begin
            r_trap_valid    <= 1'b1;
            r_trap_ecode    <= 6'd0;
            r_trap_esubcode <= 9'd0;
            r_trap_epc      <= i_commit_pc;
            r_redirect_pc   <= i_eentry;
          end else if (w_take_exc) begin
            r_trap_valid    <= 1'b1;
            r_trap_ecode    <= i_commit_ecode;
            r_trap_esubcode <= i_commit_esubcode;
            r_trap_epc      <= i_commit_pc;
            r_redirect_pc   <= w_exc_target;
          end else if (w_take_ertn) begin
            r_ertn_valid  <= 1'b1;
            r_redirect_pc <= i_era;
          end
        end
        S_FLUSH: begin
          if (r_cnt == 4'd0) begin
            r_state          <= S_REDIR;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_REDIR: begin
          if (i_redirect_ready) begin
            r_state          <= S_IDLE;
            r_redirect_valid <= 1'b0;
            r_commit_ready   <= 1'b1;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          r_flush          <= 1'b0;
          r_redirect_valid <= 1'b0;
          r_commit_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign o_commit_ready   = r_commit_ready;
  assign o_trap_valid     = r_trap_valid;
  assign o_trap_ecode     = r_trap_ecode;
  assign o_trap_esubcode  = r_trap_esubcode;
  assign o_trap_epc       = r_trap_epc;
  assign o_ertn_valid     = r_ertn_valid;
  assign o_flush          = r_flush;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl (FLUSH_CYCLES=2)
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic [5:0]  commit_ecode;
  logic [8:0]  commit_esubcode;
  logic        commit_is_ertn;
  logic        is_interrupt;
  logic [31:0] eentry;
  logic [31:0] tlbrentry;
  logic [31:0] era;
  logic        trap_valid;
  logic [5:0]  trap_ecode;
  logic [8:0]  trap_esubcode;
  logic [31:0] trap_epc;
  logic        ertn_valid;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.FLUSH_CYCLES(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_commit_valid(commit_valid), .o_commit_ready(commit_ready),
    .i_commit_pc(commit_pc), .i_commit_ecode(commit_ecode),
    .i_commit_esubcode(commit_esubcode), .i_commit_is_ertn(commit_is_ertn),
    .i_is_interrupt(is_interrupt), .i_eentry(eentry), .i_tlbrentry(tlbrentry), .i_era(era),
    .o_trap_valid(trap_valid), .o_trap_ecode(trap_ecode), .o_trap_esubcode(trap_esubcode),
    .o_trap_epc(trap_epc), .o_ertn_valid(ertn_valid), .o_flush(flush),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .i_redirect_ready(redirect_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns to IDLE; a missed handshake within the budget is reported as a failure.
  task automatic drain;
    redirect_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (commit_ready) break;
      tick();
    end
    chk("drain_idle", 32'(commit_ready), 32'd1);
    redirect_ready = 1'b0;
  endtask

  task automatic idle_inputs;
    commit_valid = 1'b0; commit_ecode = 6'd0; commit_esubcode = 9'd0;
    commit_is_ertn = 1'b0; is_interrupt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; redirect_ready = 1'b0; commit_pc = 32'd0;
    eentry = 32'h1c008000; tlbrentry = 32'h1c00f000; era = 32'd0;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;

    // reset state: {ready, trap, ertn, flush, rvalid}
    chk("rst_ctrl", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b10000);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_epc", trap_epc, 32'd0);
    chk("rst_cause", {17'd0, trap_ecode, trap_esubcode}, 32'd0);

    // idle commits without events
    commit_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      commit_pc = 32'h1c000000 + 32'(4 * i);
      tick();
      chk("idle_ctrl", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b10000);
    end

    // exception 0x0D
    commit_pc = 32'h1c000100; commit_ecode = 6'h0D; commit_esubcode = 9'h005;
    tick();
    idle_inputs(); eentry = 32'hdeadbeef;
    chk("exc_t1_ctrl", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b01010);
    chk("exc_t1_ecode", 32'(trap_ecode), 32'h0D);
    chk("exc_t1_esub", 32'(trap_esubcode), 32'h005);
    chk("exc_t1_epc", trap_epc, 32'h1c000100);
    tick();
    chk("exc_t2_ctrl", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b00010);
    tick();
    chk("exc_t3_ctrl", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b00001);
    chk("exc_t3_rpc", redirect_pc, 32'h1c008000);

    // backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ctrl", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b00001);
      chk("hold_rpc", redirect_pc, 32'h1c008000);
    end
    eentry = 32'h1c008000;
    commit_valid = 1'b1; commit_pc = 32'h1c000200; commit_ecode = 6'h02;
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("hs_done_ctrl", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b10000);
    tick();
    chk("next_exc_trap", 32'(trap_valid), 32'd1);
    chk("next_exc_ecode", 32'(trap_ecode), 32'h02);
    chk("next_exc_epc", trap_epc, 32'h1c000200);
    idle_inputs();
    drain();

    // interrupt + exception + ertn on one commit
    commit_valid = 1'b1; commit_pc = 32'h1c000300; commit_ecode = 6'h0B;
    commit_is_ertn = 1'b1; is_interrupt = 1'b1; era = 32'h11110000;
    tick();
    idle_inputs();
    chk("prio_ctrl", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b01010);
    chk("prio_cause", {17'd0, trap_ecode, trap_esubcode}, 32'd0);
    chk("prio_epc", trap_epc, 32'h1c000300);
    tick(); tick();
    chk("prio_rpc", redirect_pc, 32'h1c008000);
    drain();

    // ertn with era changing after acceptance
    commit_valid = 1'b1; commit_is_ertn = 1'b1; commit_pc = 32'h1c000500; era = 32'h1c000204;
    tick();
    idle_inputs(); era = 32'd0;
    chk("ertn_ctrl", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b00110);
    tick();
    chk("ertn_t2_ctrl", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b00010);
    tick();
    chk("ertn_rvalid", 32'(redirect_valid), 32'd1);
    chk("ertn_rpc", redirect_pc, 32'h1c000204);
    drain();

    // pending interrupt with no commit, taken at the next valid commit
    is_interrupt = 1'b1;
    tick();
    chk("irq_wait", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b10000);
    commit_valid = 1'b1; commit_pc = 32'h1c000400;
    tick();
    idle_inputs();
    chk("irq_take", 32'(trap_valid), 32'd1);
    chk("irq_epc", trap_epc, 32'h1c000400);
    drain();

    // reset during FLUSH drops the sequence
    commit_valid = 1'b1; commit_pc = 32'h1c000600; commit_ecode = 6'h07;
    tick();
    idle_inputs();
    chk("rstf_pre", 32'(flush), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstf_ctrl", {27'd0, commit_ready, trap_valid, ertn_valid, flush, redirect_valid}, 32'b10000);
    chk("rstf_rpc", redirect_pc, 32'd0);
    chk("rstf_epc", trap_epc, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rstf_norv", 32'(redirect_valid), 32'd0);
    end

    // ecode 0x3F target selection
    commit_valid = 1'b1; commit_pc = 32'h1c000700; commit_ecode = 6'h3F; commit_esubcode = 9'd0;
    tick();
    idle_inputs();
    chk("tlbr_cause", {17'd0, trap_ecode, trap_esubcode}, {17'd0, 6'h3F, 9'd0});
    tick(); tick();
`ifdef TRAP_TLBR_EN
    chk("tlbr_rpc", redirect_pc, 32'h1c00f000);
`else
    chk("tlbr_rpc", redirect_pc, 32'h1c008000);
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
